// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor, one bit per clock.
// A single full-adder cell plus carry flop; start/busy/done handshake.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic fa_s;
    logic fa_c;
    logic last_bit;

    // Full-adder cell on the LSBs of the shift registers.
    always_comb begin
        fa_s     = sh_a[0] ^ sh_b[0] ^ carry;
        fa_c     = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));
        last_bit = (cnt == LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; start outside IDLE is dropped.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand load, serial shift, and result capture on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a     <= '0;
            sh_b     <= '0;
            acc      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= sub ? ~b : b;
                        carry <= sub ? ~c_in : c_in;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= {fa_s, acc[WIDTH-1:1]};
                    sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
                    sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        sum      <= {fa_s, acc[WIDTH-1:1]};
                        c_out    <= fa_c;
                        overflow <= carry ^ fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
